// File: rtl/quad_decoder_opc_if.sv
// Pin-side bundle for the quadrature front end: raw encoder/button inputs in, OPC command stream out.
// OPC is a single-cycle strobe (non-zero for one CLK per event); there is no backpressure from the counter.
interface quad_decoder_opc_if;
    logic       A;
    logic       B;
    logic       BTN;
    logic [1:0] OPC;
    logic       DIR;
    logic       ERR;

    modport master (output A, output B, output BTN, input OPC, input DIR, input ERR);
    modport slave  (input A, input B, input BTN, output OPC, output DIR, output ERR);
endinterface

// File: rtl/quad_decoder_opc.sv
// Quadrature encoder + clear button to OPC command decoder (0 hold, 1 inc, 2 dec, 3 clear).
// Optional debounce filter on every synchronized input is enabled with `define QUAD_DEBOUNCE_EN.
module quad_decoder_opc #(
    parameter bit X4              = 1'b1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    quad_decoder_opc_if.slave   bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        INIT0 = 2'd0,
        INIT1 = 2'd1,
        TRACK = 2'd2
    } state_t;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end

    state_t     state;
    state_t     state_nx;
    logic [2:0] sync1;      // {A, B, BTN} first stage
    logic [2:0] sync2;      // {A, B, BTN} second stage
    logic [1:0] prev;
    logic [1:0] prev_nx;
    logic       btn_prev;
    logic       btn_prev_nx;
    logic [1:0] opc_nx;
    logic       dir_nx;
    logic       err_nx;
    logic [1:0] cur;
    logic       btn_cur;
    logic       step_cw;
    logic       step_ccw;
    logic       step_bad;
    logic       btn_rise;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {bus.A, bus.B, bus.BTN};
            sync2 <= sync1;
        end
    end

`ifdef QUAD_DEBOUNCE_EN
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [2:0]  filt;
    logic [15:0] deb_cnt [3];

    // During INIT the filters follow the first stage so they agree with PREV on entry to TRACK.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filt <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (state != TRACK) begin
                    filt[i]    <= sync1[i];
                    deb_cnt[i] <= 16'd0;
                end else if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= 16'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= 16'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign cur     = filt[2:1];
    assign btn_cur = filt[0];
`else
    assign cur     = sync2[2:1];
    assign btn_cur = sync2[0];
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= INIT0;
            prev     <= 2'b00;
            btn_prev <= 1'b0;
            bus.OPC  <= 2'd0;
            bus.DIR  <= 1'b0;
            bus.ERR  <= 1'b0;
        end else begin
            state    <= state_nx;
            prev     <= prev_nx;
            btn_prev <= btn_prev_nx;
            bus.OPC  <= opc_nx;
            bus.DIR  <= dir_nx;
            bus.ERR  <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        btn_prev_nx = btn_prev;
        opc_nx      = 2'd0;
        dir_nx      = bus.DIR;
        err_nx      = 1'b0;
        step_cw     = 1'b0;
        step_ccw    = 1'b0;
        step_bad    = 1'b0;
        btn_rise    = 1'b0;
        case (state)
            INIT0: begin
                state_nx = INIT1;
            end
            INIT1: begin
                // The second stage still holds its reset zeros here; the first stage is what
                // it will present next cycle, so loading it avoids a fake 00->11 jump.
                state_nx    = TRACK;
                prev_nx     = sync1[2:1];
                btn_prev_nx = sync1[0];
            end
            TRACK: begin
                prev_nx     = cur;
                btn_prev_nx = btn_cur;
                btn_rise    = btn_cur & ~btn_prev;
                step_bad    = ((cur ^ prev) == 2'b11);
                case ({prev, cur})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: step_cw  = 1'b1;
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: step_ccw = 1'b1;
                    default: ;
                endcase
                if (step_cw) begin
                    dir_nx = 1'b1;
                end else if (step_ccw) begin
                    dir_nx = 1'b0;
                end
                err_nx = step_bad;
                if (btn_rise) begin
                    opc_nx = 2'd3;
                end else if (step_cw && (X4 || cur == 2'b00)) begin
                    opc_nx = 2'd1;
                end else if (step_ccw && (X4 || cur == 2'b00)) begin
                    opc_nx = 2'd2;
                end
            end
            default: begin
                state_nx = INIT0;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_quad_decoder_opc.sv
// Bench for quad_decoder_opc: an X4=1 and an X4=0 instance share the same encoder/button stimulus.
// Expected OPC/ERR/DIR events are queued with their due cycle when driven and compared when they appear.
module tb_quad_decoder_opc;

  localparam int W = 36;  // {due[31:0], opc[1:0], err, dir}
`ifdef QUAD_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  logic a = 1'b0;
  logic b = 1'b0;
  logic btn = 1'b0;
  logic [1:0] st_x4;
  logic [1:0] st_x1;

  quad_decoder_opc_if if_x4 ();
  quad_decoder_opc_if if_x1 ();
  assign if_x4.A = a;
  assign if_x4.B = b;
  assign if_x4.BTN = btn;
  assign if_x1.A = a;
  assign if_x1.B = b;
  assign if_x1.BTN = btn;

  quad_decoder_opc #(.X4(1'b1), .DEBOUNCE_CYCLES(4)) dut_x4 (
    .CLK(CLK), .RESET(RESET), .bus(if_x4), .state_dbg(st_x4)
  );
  quad_decoder_opc #(.X4(1'b0), .DEBOUNCE_CYCLES(4)) dut_x1 (
    .CLK(CLK), .RESET(RESET), .bus(if_x1), .state_dbg(st_x1)
  );

  logic [1:0] opc_o [2];
  logic       err_o [2];
  logic       dir_o [2];
  assign opc_o[0] = if_x4.OPC;
  assign opc_o[1] = if_x1.OPC;
  assign err_o[0] = if_x4.ERR;
  assign err_o[1] = if_x1.ERR;
  assign dir_o[0] = if_x4.DIR;
  assign dir_o[1] = if_x1.DIR;

  // scoreboard
  logic [W-1:0] exp_q [2][$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic [1:0] prev_ab = 2'b00;
  logic prev_btn = 1'b0;
  logic exp_dir [2];
  logic [3:0] cnt4 [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_cw(input logic [1:0] p, input logic [1:0] n);
    return (p == 2'b00 && n == 2'b01) || (p == 2'b01 && n == 2'b11) ||
           (p == 2'b11 && n == 2'b10) || (p == 2'b10 && n == 2'b00);
  endfunction

  // Monitor: an event (or a due expectation) pops the queue; a counter follows the DUT's OPC.
  always @(negedge CLK) begin
    logic ev;
    logic [W-1:0] e;
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        cnt4[i] = 4'd0;
      end else begin
        case (opc_o[i])
          2'd1: cnt4[i] = cnt4[i] + 4'd1;
          2'd2: cnt4[i] = cnt4[i] - 4'd1;
          2'd3: cnt4[i] = 4'd0;
          default: ;
        endcase
      end
      if (mon_en) begin
        ev = (opc_o[i] != 2'd0) || err_o[i];
        e = '0;
        if (exp_q[i].size() > 0) e = exp_q[i][0];
        if (ev || (exp_q[i].size() > 0 && int'(e[35:4]) <= cyc)) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_event_dut%0d", i), {29'd0, opc_o[i], err_o[i]}, 32'd0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("opc_dut%0d", i), {30'd0, opc_o[i]}, {30'd0, e[3:2]});
            check($sformatf("err_dut%0d", i), {31'd0, err_o[i]}, {31'd0, e[1]});
            check($sformatf("dir_dut%0d", i), {31'd0, dir_o[i]}, {31'd0, e[0]});
            check($sformatf("cycle_dut%0d", i), cyc, e[35:4]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [1:0] ab, input logic btn_v);
    logic cw;
    logic ccw;
    logic bad;
    logic rise;
    logic [1:0] opc;
    int due;
    cw = is_cw(prev_ab, ab);
    ccw = is_cw(ab, prev_ab);
    bad = ((prev_ab ^ ab) == 2'b11);
    rise = btn_v & ~prev_btn;
    due = cyc + 3 + DEB;
    for (int i = 0; i < 2; i++) begin
      opc = 2'd0;
      if (rise) opc = 2'd3;
      else if (cw && (i == 0 || ab == 2'b00)) opc = 2'd1;
      else if (ccw && (i == 0 || ab == 2'b00)) opc = 2'd2;
      if (cw) exp_dir[i] = 1'b1;
      else if (ccw) exp_dir[i] = 1'b0;
      if (opc != 2'd0 || bad) exp_q[i].push_back({due[31:0], opc, bad, exp_dir[i]});
    end
    prev_ab = ab;
    prev_btn = btn_v;
    a = ab[1];
    b = ab[0];
    btn = btn_v;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    mon_en = 1'b0;
    a = ab[1];
    b = ab[0];
    btn = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      exp_dir[i] = 1'b0;
      check($sformatf("rst_opc_dut%0d", i), {30'd0, opc_o[i]}, 32'd0);
      check($sformatf("rst_err_dut%0d", i), {31'd0, err_o[i]}, 32'd0);
      check($sformatf("rst_dir_dut%0d", i), {31'd0, dir_o[i]}, 32'd0);
    end
    check("rst_state_x4", {30'd0, st_x4}, 32'd0);
    check("rst_state_x1", {30'd0, st_x1}, 32'd0);
    prev_ab = ab;
    prev_btn = 1'b0;
    RESET = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic press_clear();
    drive(prev_ab, 1'b1);
    idle(8);
    drive(prev_ab, 1'b0);
    idle(8);
  endtask

  initial begin
    // reset with A=B=1 held; INIT must not produce a command or error
    do_reset(2'b11);
    idle(10);
    check("track_state_x4", {30'd0, st_x4}, 32'd2);
    check("track_state_x1", {30'd0, st_x1}, 32'd2);

    drive(2'b10, 1'b0); idle(8);
    drive(2'b00, 1'b0); idle(8);
    press_clear();

    // full CW cycle
    drive(2'b01, 1'b0); idle(8);
    drive(2'b11, 1'b0); idle(8);
    drive(2'b10, 1'b0); idle(8);
    drive(2'b00, 1'b0); idle(8);
    check("cw_count_x4", {28'd0, cnt4[0]}, 32'd4);
    check("cw_count_x1", {28'd0, cnt4[1]}, 32'd1);
    check("cw_dir_x4", {31'd0, dir_o[0]}, 32'd1);
    press_clear();

    // two full CCW cycles
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b0); idle(8);
      drive(2'b11, 1'b0); idle(8);
      drive(2'b01, 1'b0); idle(8);
      drive(2'b00, 1'b0); idle(8);
    end
    check("ccw_count_x1", {28'd0, cnt4[1]}, 32'd14);
    check("ccw_count_x4", {28'd0, cnt4[0]}, 32'd8);
    check("ccw_dir_x1", {31'd0, dir_o[1]}, 32'd0);

    // illegal jump then a legal CW step
    drive(2'b11, 1'b0); idle(8);
    drive(2'b10, 1'b0); idle(8);

    // clear coinciding with a CW step, button held
    drive(2'b00, 1'b1); idle(20);
    drive(2'b01, 1'b1); idle(8);
    check("btn_hold_dir_x4", {31'd0, dir_o[0]}, 32'd1);
    drive(2'b01, 1'b0); idle(8);

`ifdef QUAD_DEBOUNCE_EN
    // 3-cycle glitch on A must be filtered out
    a = 1'b1;
    idle(3);
    a = 1'b0;
    idle(12);
    drive(2'b11, 1'b0); idle(8);
`endif

    // reset between the input edge and the command: command is lost
    drive(2'b11, 1'b0);
    idle(1);
    do_reset(2'b11);
    idle(10);
    check("post_rst_dir_x4", {31'd0, dir_o[0]}, 32'd0);
    check("post_rst_state_x1", {30'd0, st_x1}, 32'd2);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("queue_drained_dut%0d", i), exp_q[i].size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_decoder_opc.md
# quad_decoder_opc

Quadrature rotary-encoder front end that converts raw A/B channel inputs and a clear button into the 2-bit OPC command stream consumed by the team's up/down counter. OPC values: 0 = hold, 1 = increment, 2 = decrement, 3 = clear. It sits between the board pins and the counter, and its OPC output connects directly to the counter's OPC input on the same CLK. Each decoded step produces exactly one single-cycle command.

## Interface
- X4, default 1: 1 = one command per Gray edge (4 per detent); 0 = one command per full cycle (only on entry to AB=00)
- DEBOUNCE_CYCLES, default 16: stable-sample count for the debounce filter (used only with QUAD_DEBOUNCE_EN; legal range 1..65535)
- CLK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- A  input  1  encoder channel A, asynchronous to CLK
- B  input  1  encoder channel B, asynchronous to CLK
- BTN  input  1  clear push-button, asynchronous, active-high
- OPC  output  2  command to counter: 0 hold, 1 inc, 2 dec, 3 clear; non-zero for exactly one cycle per event
- DIR  output  1  last decoded direction: 1 = CW, 0 = CCW
- ERR  output  1  one-cycle pulse on an illegal transition (A and B both changed between consecutive samples)

## Operation
- A, B and BTN each pass through a 2-FF synchronizer. All synchronizer flops reset to 0.
- FSM states:
  - INIT0 -> INIT1 -> TRACK, one cycle each after RESET deasserts.
  - In INIT1, PREV <= {A_s, B_s} and BTN_prev <= BTN_s. No command or error is emitted.
  - TRACK persists until RESET.
- CW Gray sequence is 00->01->11->10->00; CCW is the reverse. Bit order is {A,B}.
- TRACK, per cycle, compares CUR = {A_s, B_s} with PREV:
  - CUR == PREV: OPC = 0.
  - One-step CW: OPC = 1 and DIR = 1.
  - One-step CCW: OPC = 2 and DIR = 0.
  - Both bits changed: OPC = 0, ERR = 1, DIR unchanged.
  - PREV <= CUR in every case.
- With X4 = 0, a command is issued only for 10->00 (CW, OPC = 1) and 01->00 (CCW, OPC = 2). Other legal steps still update PREV and DIR but give OPC = 0.
- A BTN_s rising edge (BTN_s = 1, BTN_prev = 0) gives OPC = 3 for one cycle. BTN held high gives no further clears.
- Simultaneous clear and step: clear wins (OPC = 3). The step is discarded, but PREV and DIR still update.
- Simultaneous clear and illegal transition: OPC = 3 and ERR = 1.
- OPC, DIR and ERR are registered outputs, with no combinational path from any input.

## Timing
- Reset values: OPC = 0, DIR = 0, ERR = 0, FSM = INIT0, PREV = 00, BTN_prev = 0, debounce counters = 0.
- RESET mid-operation immediately forces all reset values. A pending command is lost, never emitted late.
- Latency without debounce: an input change set up before rising edge N appears on OPC/ERR after edge N+2 and is valid for one cycle.
- Encoder edges spaced closer than 1 CLK may be seen as one double change, which raises ERR. Legal operation requires at least 1 CLK between A/B edges (DEBOUNCE_CYCLES+1 with debounce).
- The first command after reset is possible on the cycle after TRACK is entered, i.e. no earlier than edge 3 after RESET deasserts.

## Configuration
- QUAD_DEBOUNCE_EN defined:
  - Each synchronized input gets a 16-bit filter. The filtered value changes only after the raw synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - The counter restarts on any sample equal to the filtered value.
  - The FSM and edge detection use the filtered values.
  - Latency becomes edge N+2+DEBOUNCE_CYCLES.
  - Filtered values reset to 0 and are loaded through INIT like the raw values.
- QUAD_DEBOUNCE_EN undefined: no filter logic is generated, DEBOUNCE_CYCLES is ignored, and latency is N+2.

## Test plan
- Reset with A=1, B=1 held: after RESET falls, run 10 cycles -> OPC = 0 and ERR = 0 throughout. INIT loads PREV = 11 with no spurious command.
- X4 = 1, no debounce: drive a full CW cycle 00->01->11->10->00, 8 CLK per step -> four OPC = 1 pulses, each one cycle wide and 3 cycles after its edge. DIR = 1. A counter attached to OPC reads 4.
- X4 = 0: two full CCW cycles -> exactly two OPC = 2 pulses, each on the 01->00 step. DIR = 0. Counter wraps 0 -> 15 -> 14.
- Illegal jump 00->11 in one cycle -> ERR = 1 for one cycle, OPC = 0, DIR unchanged. A following 11->10 gives OPC = 1.
- BTN rises on the same cycle as a CW step, then is held 20 cycles -> a single OPC = 3 pulse and no OPC = 1. DIR = 1. No further clears.
- QUAD_DEBOUNCE_EN with DEBOUNCE_CYCLES = 4:
  - 3-cycle glitch on A -> no OPC.
  - A stable for 6 cycles -> one OPC = 1 at edge N+6.
  - RESET asserted between the edge and the command -> no OPC emitted.
